// File: rtl/local_store.sv
// local_store: 32 KB single-port quadword local store with a fixed-latency load pipeline.
// Define LS_INIT_CLEAR_EN to zero the whole array after every reset before accepting requests.
module local_store #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 128,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ls_req,
    input  logic                  ls_wrt_en,
    input  logic [0:ADDR_WIDTH-1] ls_address,
    input  logic [0:DATA_WIDTH-1] ls_wrt_data,
    output logic [0:DATA_WIDTH-1] ls_rd_data,
    output logic                  ls_rd_valid,
    output logic                  ls_ready
);
    localparam int IDX_W = ADDR_WIDTH - 4;
    localparam int DEPTH = 1 << IDX_W;

    logic [0:DATA_WIDTH-1]   r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_vld;
    logic [0:DATA_WIDTH-1]   r_dat [READ_LATENCY];
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [0:DATA_WIDTH-1]   w_wr_data;
    logic                    w_we;
    logic                    w_rd;
    logic                    w_unused_lsb;

    assign w_idx        = ls_address[0:IDX_W-1];
    assign w_unused_lsb = ^ls_address[IDX_W:ADDR_WIDTH-1];
    assign w_rd         = ls_req && ls_ready && !ls_wrt_en;

`ifdef LS_INIT_CLEAR_EN
    typedef enum logic {S_CLEAR, S_READY} state_t;
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter parks on the last line instead of wrapping; READY is terminal.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ls_ready    = 1'b0;
        w_we        = ls_req && ls_wrt_en;
        w_wr_idx    = w_idx;
        w_wr_data   = ls_wrt_data;
        if (r_state == S_CLEAR) begin
            w_we        = 1'b1;
            w_wr_idx    = r_cnt;
            w_wr_data   = '0;
            w_state_nxt = (r_cnt == '1) ? S_READY : S_CLEAR;
            w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        end else begin
            ls_ready = 1'b1;
        end
    end
`else
    assign ls_ready  = 1'b1;
    assign w_we      = ls_req && ls_wrt_en;
    assign w_wr_idx  = w_idx;
    assign w_wr_data = ls_wrt_data;
`endif

    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_wr_idx] <= w_wr_data;
    end

    // Data stages advance only behind a valid bit, so the last stage holds the last load result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= w_rd;
            if (w_rd) r_dat[0] <= r_mem[w_idx];
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign ls_rd_valid = r_vld[READ_LATENCY-1];
    assign ls_rd_data  = r_dat[READ_LATENCY-1];
endmodule

// File: doc/local_store.md
# local_store

Single-port 128-bit local store that services load/store requests issued by the odd pipe's load/store stage. It is the memory side of the odd pipe's local-store interface. It holds 32 KB as 2048 quadword lines, accepts one request per cycle, and returns load data through a fixed-latency read pipeline with a valid strobe. An optional post-reset sweep zeroes the whole array before the first request is accepted.

## Interface
- ADDR_WIDTH, 15, byte address width; line count DEPTH = 2^(ADDR_WIDTH-4) = 2048
- DATA_WIDTH, 128, quadword line width
- READ_LATENCY, 2, cycles from read acceptance to data valid; legal range 1..4
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ls_req  in  1  request valid
- ls_wrt_en  in  1  1 = store, 0 = load; qualified by ls_req
- ls_address  in  [0:ADDR_WIDTH-1]  byte address, bit 0 is the MSB; bits [0:10] form the line index; bits [11:14] are ignored (quadword aligned)
- ls_wrt_data  in  [0:DATA_WIDTH-1]  store data
- ls_rd_data  out  [0:DATA_WIDTH-1]  load data
- ls_rd_valid  out  1  one-cycle pulse marking ls_rd_data valid
- ls_ready  out  1  block accepts requests this cycle

## Operation
- A request is accepted on a rising edge where ls_req && ls_ready. When ls_ready is low, requests are dropped silently. There is no buffering and no error flag.
- Store: the line is written at the accepting edge with all 128 bits and no byte masks.
- Load: the array line is sampled at the accepting edge and pushed into a READ_LATENCY-deep valid/data shift pipeline. The pipeline is fully pipelined, so one load per cycle is sustained and results return in issue order.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later. A single port means there is never a same-edge read and write.
- ls_rd_data holds its last value while ls_rd_valid is low.
- State machine, with the macro defined:
  - CLEAR: a line counter runs 0..DEPTH-1 and writes zero to one line per cycle; ls_ready = 0.
  - After line DEPTH-1 is written, go to READY.
  - READY: ls_ready = 1, normal service; this is a terminal state until reset.
- Without the macro, only READY exists.
- Reset mid-operation:
  - The read pipeline valid bits clear immediately, so in-flight loads never produce ls_rd_valid.
  - ls_rd_data goes to 0.
  - The FSM returns to CLEAR (macro defined) and the line counter restarts at 0.

## Timing
- Reset values: ls_rd_valid = 0, ls_rd_data = 0, and the line counter = 0.
- ls_ready resets to 0 with the macro defined, and to 1 without it.
- Load latency: the load accepted at edge N has ls_rd_valid = 1 and ls_rd_data valid in the cycle after edge N+READ_LATENCY-1. With READ_LATENCY = 2, data is valid between edges N+1 and N+2.
- Sweep: the first rising edge with reset high clears line 0. Edge k clears line k-1. ls_ready rises after edge DEPTH (2048) and the first acceptable request is at edge DEPTH+1.
- Store has no response strobe; it completes at the accepting edge.
- The counter is 11 bits and must not wrap. CLEAR exits exactly on terminal count.

## Configuration
- LS_INIT_CLEAR_EN defined:
  - Adds the CLEAR state and the line counter.
  - The array is all zeros when ls_ready first rises.
  - ls_ready is low for DEPTH cycles after every reset.
- LS_INIT_CLEAR_EN undefined:
  - No sweep logic; ls_ready is tied to 1.
  - Array contents after reset are undefined (X in simulation) until written.

## Test plan
- Sweep (macro defined): release reset → ls_ready stays 0 for 2048 edges, then rises; load from 0x0050 → ls_rd_valid pulse with ls_rd_data = 0.
- Store/load: store 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x0120, then load 0x012F → same data exactly 2 cycles after acceptance, with a one-cycle ls_rd_valid pulse (low bits ignored).
- Read-after-write: store 128'hA5 to line 1 at edge N, load line 1 at edge N+1 → returns 128'hA5, not stale data.
- Streaming: preload lines 0..3 with 1..4, then issue loads on 4 consecutive cycles → 4 consecutive valid cycles carrying 1,2,3,4 in order.
- Reset in flight: accept a load, assert reset the next cycle → no ls_rd_valid, ls_rd_data = 0, ls_ready = 0, and the sweep restarts from line 0.
- Dropped request: store 128'hFF to 0x0000 while ls_ready = 0 during the sweep; after ready, load 0x0000 → 0.
